// File: rtl/hilo_muldiv_unit.sv
// HI/LO owning multiply/divide unit: one bit per cycle shift-add multiply and restoring divide.
// Optional HILO_MD_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are zero.
module hilo_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_MD_START,
  input  logic [11:0]     IN_MD_CONTROL,
  input  logic [XLEN-1:0] IN_MD_RS,
  input  logic [XLEN-1:0] IN_MD_RT,
  output logic [XLEN-1:0] OUT_MD_HI,
  output logic [XLEN-1:0] OUT_MD_LO,
  output logic            OUT_MD_BUSY,
  output logic            OUT_MD_DONE,
  output logic            OUT_MD_DIVZ
);

  localparam logic [5:0] CLASS_MD = 6'b000011;
  localparam logic [5:0] F_MTHI   = 6'h11;
  localparam logic [5:0] F_MTLO   = 6'h13;
  localparam logic [5:0] F_MULT   = 6'h18;
  localparam logic [5:0] F_MULTU  = 6'h19;
  localparam logic [5:0] F_DIV    = 6'h1A;
  localparam logic [5:0] F_DIVU   = 6'h1B;
  localparam int unsigned CW      = $clog2(XLEN + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;     // multiply: product; divide: {remainder, dividend/quotient}
  logic [2*XLEN-1:0] mcand;   // multiply: shifted multiplicand; divide: divisor in low half
  logic [XLEN-1:0]   mplier;
  logic              op_div, op_div_zero, neg_main, neg_rem;

  logic              req_ok, is_signed, is_mul, is_div, is_mthi, is_mtlo, accept_md;
  logic              rs_neg, rt_neg, last_iter;
  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic [2*XLEN-1:0] prod_add, prod_fix;
  logic [XLEN-1:0]   quo, rem, lo_res, hi_res;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last_iter = (cnt == CW'(XLEN - 1));
`ifdef HILO_MD_EARLY_OUT_EN
    if (!op_div && mplier[XLEN-1:1] == '0) last_iter = 1'b1;
`else
`endif
    unique case (state)
      ST_IDLE: if (accept_md) state_nxt = ST_RUN;
      ST_RUN:  if (last_iter) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ok    = IN_MD_START && (IN_MD_CONTROL[11:6] == CLASS_MD);
    is_signed = (IN_MD_CONTROL[5:0] == F_MULT) || (IN_MD_CONTROL[5:0] == F_DIV);
    is_mul    = req_ok && ((IN_MD_CONTROL[5:0] == F_MULT) || (IN_MD_CONTROL[5:0] == F_MULTU));
    is_div    = req_ok && ((IN_MD_CONTROL[5:0] == F_DIV)  || (IN_MD_CONTROL[5:0] == F_DIVU));
    is_mthi   = req_ok && (IN_MD_CONTROL[5:0] == F_MTHI) && (state == ST_IDLE);
    is_mtlo   = req_ok && (IN_MD_CONTROL[5:0] == F_MTLO) && (state == ST_IDLE);
    accept_md = (state == ST_IDLE) && (is_mul || is_div);
    OUT_MD_BUSY = (state != ST_IDLE);

    rs_neg = is_signed && IN_MD_RS[XLEN-1];
    rt_neg = is_signed && IN_MD_RT[XLEN-1];
    rs_mag = rs_neg ? -IN_MD_RS : IN_MD_RS;
    rt_mag = rt_neg ? -IN_MD_RT : IN_MD_RT;

    // Remainder is < divisor before the shift, so the difference always fits XLEN bits.
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    rem_diff = rem_sh - {1'b0, mcand[XLEN-1:0]};
    prod_add = acc + (mplier[0] ? mcand : '0);

    prod_fix = neg_main ? -acc : acc;
    quo      = acc[XLEN-1:0];
    rem      = acc[2*XLEN-1:XLEN];
    // Divide by zero yields all-ones quotient regardless of operand signs.
    lo_res   = op_div_zero ? '1 : (neg_main ? -quo : quo);
    hi_res   = neg_rem ? -rem : rem;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_MD_HI   <= '0;
      OUT_MD_LO   <= '0;
      OUT_MD_DONE <= 1'b0;
      OUT_MD_DIVZ <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      op_div      <= 1'b0;
      op_div_zero <= 1'b0;
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
    end else begin
      OUT_MD_DONE <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (is_mthi) OUT_MD_HI <= IN_MD_RS;
          if (is_mtlo) OUT_MD_LO <= IN_MD_RS;
          if (accept_md) begin
            cnt         <= '0;
            OUT_MD_DIVZ <= 1'b0;
            op_div      <= is_div;
            op_div_zero <= is_div && (IN_MD_RT == '0);
            neg_main    <= rs_neg ^ rt_neg;
            neg_rem     <= is_div && rs_neg;
            if (is_div) begin
              acc    <= {{XLEN{1'b0}}, rs_mag};
              mcand  <= {{XLEN{1'b0}}, rt_mag};
              mplier <= '0;
            end else begin
              acc    <= '0;
              mcand  <= {{XLEN{1'b0}}, rs_mag};
              mplier <= rt_mag;
            end
          end
        end
        ST_RUN: begin
          cnt <= cnt + CW'(1);
          if (op_div) begin
            if (!rem_diff[XLEN])
              acc <= {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
              acc <= {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
          end else begin
            acc    <= prod_add;
            mcand  <= {mcand[2*XLEN-2:0], 1'b0};
            mplier <= {1'b0, mplier[XLEN-1:1]};
          end
        end
        ST_FIX: begin
          if (op_div) begin
            OUT_MD_HI   <= hi_res;
            OUT_MD_LO   <= lo_res;
            OUT_MD_DIVZ <= op_div_zero;
          end else begin
            OUT_MD_HI <= prod_fix[2*XLEN-1:XLEN];
            OUT_MD_LO <= prod_fix[XLEN-1:0];
          end
          OUT_MD_DONE <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Sits beside and upstream of the combinational ALU. It takes the same 12-bit control word {class[11:6], funct[5:0]} and rs/rt operands.
- Its HI/LO outputs drive the ALU operand path for MFHI/MFLO.
- Replaces single-cycle 64-bit multiply/divide with a shift-add / restoring-divide datapath that runs one bit per cycle.

Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN bits; the iteration count equals XLEN.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_MD_START  input  1  request strobe, sampled at CLK edge.
- IN_MD_CONTROL  input  12  control word; [11:6] must equal 6'b000011 for the unit to act.
- IN_MD_RS  input  XLEN  operand rs (multiplicand / dividend).
- IN_MD_RT  input  XLEN  operand rt (multiplier / divisor).
- OUT_MD_HI  output  XLEN  HI register.
- OUT_MD_LO  output  XLEN  LO register.
- OUT_MD_BUSY  output  1  operation in flight; issue stage must stall MF/MT/MULT/DIV while high.
- OUT_MD_DONE  output  1  one-cycle pulse when HI/LO take a MULT/DIV result.
- OUT_MD_DIVZ  output  1  divide-by-zero flag, valid with DONE.

Behaviour:
- Reset (async, RST_N=0): all outputs 0, state IDLE, iteration counter 0. This applies mid-operation too: the in-flight result is discarded and no DONE is issued.
- Recognised funct codes:
  - 0x18 MULT
  - 0x19 MULTU
  - 0x1A DIV
  - 0x1B DIVU
  - 0x11 MTHI
  - 0x13 MTLO
- Any other funct, or class ≠ 000011: the request is ignored.
- States: IDLE, RUN, FIX.
- IDLE, START with MTHI/MTLO:
  - At edge E0, HI (or LO) ← rs.
  - Stays IDLE; BUSY stays 0; no DONE.
  - New value visible the cycle after E0.
- IDLE, START with MULT*/DIV*:
  - At E0, latch operands; for signed ops, latch magnitudes plus a sign record.
  - Counter ← 0, BUSY ← 1, DIVZ ← 0, state → RUN.
- RUN: one bit per edge.
  - Multiply: 2*XLEN-bit accumulator, shift-add on the multiplier LSB.
  - Divide: restoring subtract of the divisor from the partial remainder; the quotient bit shifts in.
  - After XLEN RUN edges (E1..E32 at default), state → FIX.
- FIX, edge E33:
  - Apply sign correction.
  - Write HI/LO; DONE ← 1 for exactly one cycle; BUSY ← 0; state → IDLE.
- Default latency: DONE high and results visible in the cycle after E33 (33 cycles after START is accepted).
- Arithmetic rules:
  - MULT: {HI,LO} = signed 64-bit two's-complement product.
  - MULTU: unsigned product.
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - DIV overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
  - Divide by zero: LO = 0xFFFFFFFF, HI = rs, DIVZ = 1 with DONE. Same cycle count.
- START while BUSY: ignored with no side effects; HI/LO hold their old values until FIX.
- START in the same cycle as the FIX edge: ignored (BUSY is still 1 at that edge).
- DIVZ holds until the next MULT/DIV is accepted.

Optional Feature:
- Macro HILO_MD_EARLY_OUT_EN.
- Defined: MULT/MULTU leave RUN once the remaining unshifted multiplier magnitude is zero, with at least 1 iteration. DONE then comes k+1 edges after E0, where k = max(1, bit-length of |rt|).
- Divide always takes the full XLEN iterations.
- Not defined: fixed XLEN-iteration latency for all ops.

Test Plan:
- MULT rs=0xFFFFFFFD, rt=7 → DONE in the cycle after E33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; BUSY high during E1..E33.
- DIVU rs=100, rt=7 → LO=14, HI=2. DIV rs=0xFFFFFFF9, rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV rs=0x12, rt=0 → LO=0xFFFFFFFF, HI=0x12, DIVZ=1 with DONE. A following MULTU 2×3 clears DIVZ and gives HI=0, LO=6.
- MTHI rs=0xCAFEBABE → OUT_MD_HI=0xCAFEBABE next cycle, LO unchanged, BUSY=0, DONE=0. A MULT issued while BUSY (e.g. at E5) has no effect.
- Reset mid-RUN at E10 → all outputs 0 immediately; no DONE afterwards. A fresh MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- With HILO_MD_EARLY_OUT_EN: MULTU 3×5 → DONE after 4 edges, LO=15. Without the macro, the same operation takes 33 edges.
